mbist_decoder: RTL and testbench
================================

// Module: mbist_decoder
// PURPOSE
//  - MBIST data-background decoder: maps a 3-bit pattern select (q) to a
//    DATA_WIDTH-bit test data word (data_t) written to, and compared against, memory.
//  - Sits between the MBIST controller FSM (drives q) and the memory write/compare datapath.
//  - data_t is combinational (same-delta response to q).
//  - A registered copy plus a valid flag serve pipelined compare logic.
// PARAMETERS
//  - DATA_WIDTH  8  width of data_t / data_r; must be even and >= 8.
// PORTS
//  - clk        input   1           single clock, rising-edge; used only by registered outputs.
//  - rst_n      input   1           asynchronous, active-low reset.
//  - q          input   3           pattern select from MBIST controller.
//  - data_t     output  DATA_WIDTH  combinational pattern word.
//  - pat_valid  output  1           combinational: 1 when q is a legal code (0..5).
//  - data_r     output  DATA_WIDTH  data_t registered on clk.
//  - valid_r    output  1           pat_valid registered on clk.
// BEHAVIOUR
//  - Clocking and reset: one clock (clk); reset rst_n is asynchronous and active-low.
//  - Combinational decode (MSB first, pattern repeated across DATA_WIDTH):
//    - q=000 -> 1010...10 (8b: 10101010, checkerboard)
//    - q=001 -> 0101...01 (8b: 01010101, inverse checkerboard)
//    - q=010 -> upper half 1s, lower half 0s (8b: 11110000)
//    - q=011 -> upper half 0s, lower half 1s (8b: 00001111)
//    - q=100 -> all 0s (solid 0)
//    - q=101 -> all 1s (solid 1)
//  - Illegal or unknown codes:
//    - q=110, q=111, or any X/Z bit in q -> data_t = all X ('x) and pat_valid = 0.
//    - Implement as the default branch of a full case.
//    - Benches compare data_t with ===, so the X drive is required, not a don't-care.
//  - pat_valid: 1 for q in 0..5; 0 otherwise (including X/Z in q).
//  - data_t and pat_valid follow q with zero clock latency; no state.
//  - Registered outputs (one-cycle latency):
//    - On rst_n low (async): data_r = 0, valid_r = 0, held for the whole time rst_n is low.
//    - On each rising clk edge with rst_n high: data_r <= pat_valid ? data_t : '0;
//      valid_r <= pat_valid.
//    - data_r never captures X.
//  - Reset asserted mid-operation clears data_r/valid_r immediately.
//  - data_t/pat_valid are unaffected by reset.
//  - Reset release: first capture occurs on the first rising clk edge after rst_n goes high.
// CONFIGURATION
//  - Macro MBIST_DECODER_INV_EN.
//  - Defined:
//    - Adds input port 'inv' (1 bit).
//    - When inv=1 and q is legal, data_t = bitwise complement of the table pattern
//      (data_r/valid_r follow via the same path).
//    - Illegal q still yields all X with pat_valid=0, regardless of inv.
//  - Undefined: no 'inv' port; table exactly as above.
// TESTING
//  - q left X at time 0 -> data_t === 8'bxxxxxxxx, pat_valid=0.
//  - Sweep q 0..7, check each value 1 time unit after applying it:
//    - 0..5 -> AA, 55, F0, 0F, 00, FF
//    - 6, 7 -> all X, pat_valid=0
//  - Hold rst_n=0, toggle clk, q=3'b101 -> data_r=0, valid_r=0.
//    Release rst_n; next posedge -> data_r=8'hFF, valid_r=1.
//  - q=3'b010, then posedge, then q=3'b110, then posedge
//    -> data_r: F0 after the first edge, 00 after the second; valid_r: 1, then 0.
//  - Async reset mid-run:
//    - Drop rst_n between clk edges while data_r=8'h0F -> data_r=0 immediately, without a clk edge.
//  - With MBIST_DECODER_INV_EN:
//    - q=000, inv=1 -> data_t=8'h55
//    - q=100, inv=1 -> data_t=8'hFF
//    - q=111, inv=1 -> all X

Source files
------------

// File: rtl/mbist_decoder_if.sv
// Bus between the MBIST controller and the data-background decoder.
// Optional 'inv' select is present only when MBIST_DECODER_INV_EN is defined.
interface mbist_decoder_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [2:0]            q;
`ifdef MBIST_DECODER_INV_EN
  logic                  inv;
`endif
  logic [DATA_WIDTH-1:0] data_t;
  logic                  pat_valid;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;

  // Controller side: selects the pattern, consumes the words.
  modport master (
    output q,
`ifdef MBIST_DECODER_INV_EN
    output inv,
`endif
    input  data_t,
    input  pat_valid,
    input  data_r,
    input  valid_r
  );

  // Decoder side.
  modport slave (
    input  q,
`ifdef MBIST_DECODER_INV_EN
    input  inv,
`endif
    output data_t,
    output pat_valid,
    output data_r,
    output valid_r
  );
endinterface

// File: rtl/mbist_decoder.sv
// MBIST data-background decoder: 3-bit pattern select -> DATA_WIDTH-bit word.
// data_t/pat_valid are combinational; data_r/valid_r are a one-cycle registered
// copy that is forced to zero for illegal codes, so it never holds X.
// Optional feature: define MBIST_DECODER_INV_EN to add the 'inv' complement select.
module mbist_decoder #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  mbist_decoder_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] PAT_CHK  = {(DATA_WIDTH/2){2'b10}};
  localparam logic [DATA_WIDTH-1:0] PAT_ICHK = {(DATA_WIDTH/2){2'b01}};
  localparam logic [DATA_WIDTH-1:0] PAT_HI   = {{(DATA_WIDTH/2){1'b1}}, {(DATA_WIDTH/2){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] PAT_LO   = {{(DATA_WIDTH/2){1'b0}}, {(DATA_WIDTH/2){1'b1}}};

  logic [DATA_WIDTH-1:0] data_t_c;
  logic                  pat_valid_c;
  logic [DATA_WIDTH-1:0] data_r_d, data_r_q;
  logic                  valid_r_d, valid_r_q;

  // Pattern table; illegal or unknown codes fall into the default and drive X.
  always_comb begin
    data_t_c    = '0;
    pat_valid_c = 1'b0;
    case (bus.q)
      3'b000:  begin data_t_c = PAT_CHK;  pat_valid_c = 1'b1; end
      3'b001:  begin data_t_c = PAT_ICHK; pat_valid_c = 1'b1; end
      3'b010:  begin data_t_c = PAT_HI;   pat_valid_c = 1'b1; end
      3'b011:  begin data_t_c = PAT_LO;   pat_valid_c = 1'b1; end
      3'b100:  begin data_t_c = '0;       pat_valid_c = 1'b1; end
      3'b101:  begin data_t_c = '1;       pat_valid_c = 1'b1; end
      default: begin data_t_c = 'x;       pat_valid_c = 1'b0; end
    endcase
`ifdef MBIST_DECODER_INV_EN
    if (pat_valid_c && bus.inv) data_t_c = ~data_t_c;
`endif
  end

  // Next registered value: only legal patterns are captured.
  always_comb begin
    data_r_d  = '0;
    valid_r_d = pat_valid_c;
    if (pat_valid_c) data_r_d = data_t_c;
  end

  // Registered copy for pipelined compare logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r_q  <= '0;
      valid_r_q <= 1'b0;
    end else begin
      data_r_q  <= data_r_d;
      valid_r_q <= valid_r_d;
    end
  end

  assign bus.data_t    = data_t_c;
  assign bus.pat_valid = pat_valid_c;
  assign bus.data_r    = data_r_q;
  assign bus.valid_r   = valid_r_q;

endmodule

// File: tb/tb_mbist_decoder.sv
// Scoreboard bench for mbist_decoder: stimulus pushes expected responses,
// a monitor pops and compares them at each sample point.
// X-valued expectations are only compared on 4-state simulators.
module tb_mbist_decoder;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;

  mbist_decoder_if #(.DATA_WIDTH(W)) bus ();

  mbist_decoder #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string          name;
    bit             regd;   // 0: data_t/pat_valid, 1: data_r/valid_r
    logic [W-1:0]   d;
    bit             v;
    bit             xexp;   // data must be all X
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   errors = 0;
  int   checks = 0;
  bit   four_state;
  logic probe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string name, input bit regd, input logic [W-1:0] d,
                      input bit v, input bit xexp);
    exp_t e;
    e.name = name; e.regd = regd; e.d = d; e.v = v; e.xexp = xexp;
    sb.push_back(e);
  endtask

  task automatic sample();
    -> sample_ev;
    #0;
  endtask

  // Monitor: drains the scoreboard at every sample point.
  initial begin
    exp_t         e;
    logic [W-1:0] ad;
    logic         av;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        e  = sb.pop_front();
        ad = e.regd ? bus.data_r  : bus.data_t;
        av = e.regd ? bus.valid_r : bus.pat_valid;
        if (e.xexp) begin
          if (four_state) begin
            checks++;
            if (ad !== {W{1'bx}}) begin
              errors++;
              $display("FAIL %s data: got %h want all-x", e.name, ad);
            end
          end
        end else begin
          checks++;
          if (ad !== e.d) begin
            errors++;
            $display("FAIL %s data: got %h want %h", e.name, ad, e.d);
          end
        end
        checks++;
        if (av !== e.v) begin
          errors++;
          $display("FAIL %s valid: got %b want %b", e.name, av, e.v);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  // Stimulus.
  initial begin
    logic [W-1:0] tab [0:5];
    tab[0] = 8'hAA; tab[1] = 8'h55; tab[2] = 8'hF0;
    tab[3] = 8'h0F; tab[4] = 8'h00; tab[5] = 8'hFF;
    probe = 1'bx;
    four_state = $isunknown(probe);

    rst_n  = 1'b0;
    bus.q  = 3'bxxx;
`ifdef MBIST_DECODER_INV_EN
    bus.inv = 1'b0;
`endif
    #1;
    if (four_state) push("x_init", 1'b0, '0, 1'b0, 1'b1);
    push("rst_state", 1'b1, '0, 1'b0, 1'b0);
    sample();

    // Combinational sweep of all codes.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.q = 3'(i);
      #1;
      if (i < 6) push($sformatf("sweep_q%0d", i), 1'b0, tab[i], 1'b1, 1'b0);
      else       push($sformatf("sweep_q%0d", i), 1'b0, '0, 1'b0, 1'b1);
      sample();
    end

    // Registered outputs held at zero during reset while clk toggles.
    @(negedge clk);
    bus.q = 3'b101;
    repeat (3) @(posedge clk);
    #1;
    push("rst_hold", 1'b1, '0, 1'b0, 1'b0);
    sample();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push("rel_ff", 1'b1, 8'hFF, 1'b1, 1'b0);
    sample();

    // Legal then illegal capture.
    @(negedge clk);
    bus.q = 3'b010;
    @(posedge clk); #1;
    push("cap_f0", 1'b1, 8'hF0, 1'b1, 1'b0);
    sample();
    @(negedge clk);
    bus.q = 3'b110;
    @(posedge clk); #1;
    push("cap_ill", 1'b1, '0, 1'b0, 1'b0);
    sample();

    // Async reset between edges.
    @(negedge clk);
    bus.q = 3'b011;
    @(posedge clk); #1;
    push("cap_0f", 1'b1, 8'h0F, 1'b1, 1'b0);
    sample();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    push("async_rst", 1'b1, '0, 1'b0, 1'b0);
    push("comb_in_rst", 1'b0, 8'h0F, 1'b1, 1'b0);
    sample();
    @(negedge clk);
    rst_n = 1'b1;
    bus.q = 3'b001;
    @(posedge clk); #1;
    push("cap_55", 1'b1, 8'h55, 1'b1, 1'b0);
    sample();

`ifdef MBIST_DECODER_INV_EN
    @(negedge clk);
    bus.inv = 1'b1;
    bus.q   = 3'b000;
    #1;
    push("inv_q0", 1'b0, 8'h55, 1'b1, 1'b0);
    sample();
    @(negedge clk);
    bus.q = 3'b100;
    #1;
    push("inv_q4", 1'b0, 8'hFF, 1'b1, 1'b0);
    sample();
    @(negedge clk);
    bus.q = 3'b111;
    #1;
    push("inv_q7", 1'b0, '0, 1'b0, 1'b1);
    sample();
    @(negedge clk);
    bus.q = 3'b010;
    @(posedge clk); #1;
    push("inv_cap", 1'b1, 8'h0F, 1'b1, 1'b0);
    sample();
    bus.inv = 1'b0;
`endif

    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
